// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - W x NUM_REGS register file: r0 zero, tap registers r1..rNUM_TAPS, clear engine
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_param #(
  parameter int unsigned W        = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_TAPS = 4,
  parameter int unsigned TSW      = 2
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [AW-1:0]         ctrl_writeReg,
  input  logic [W-1:0]          data_writeReg,
  input  logic [AW-1:0]         ctrl_readRegA,
  input  logic [AW-1:0]         ctrl_readRegB,
  output logic [W-1:0]          data_readRegA,
  output logic [W-1:0]          data_readRegB,
  input  logic                  tap_writeEnable,
  input  logic [TSW-1:0]        tap_sel,
  input  logic [W-1:0]          tap_data,
  output logic [NUM_TAPS*W-1:0] taps_out,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_err
);

  localparam logic [AW-1:0] PTR_LAST = AW'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic          done_q;
  logic          wr_err_q;
  logic          wr_err_d;
  logic [W-1:0]  regs_q [NUM_REGS];
  logic [W-1:0]  regs_d [NUM_REGS];

  logic          core_wr_ok;
  logic          tap_wr_ok;
  logic [AW-1:0] tap_addr;

  assign core_wr_ok = ctrl_writeEnable && !busy_q && (32'(ctrl_writeReg) > NUM_TAPS);
  assign tap_wr_ok  = tap_writeEnable && (32'(tap_sel) < NUM_TAPS);
  assign tap_addr   = AW'(tap_sel) + AW'(1);
  // Writes to r0 vanish silently; tap-range or mid-clear writes are flagged.
  assign wr_err_d   = ctrl_writeEnable && (ctrl_writeReg != '0) &&
                      (busy_q || (32'(ctrl_writeReg) <= NUM_TAPS));

  always_comb begin
    regs_d = regs_q;
    if (state_q == S_CLEAR) regs_d[ptr_q] = '0;
    if (core_wr_ok)         regs_d[ctrl_writeReg] = data_writeReg;
    if (tap_wr_ok)          regs_d[tap_addr] = tap_data;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clr_req) begin
            state_q <= S_CLEAR;
            ptr_q   <= AW'(1);
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == PTR_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_readRegA = regs_q[ctrl_readRegA];
`ifdef REGFILE_BYPASS_EN
    if (core_wr_ok && (ctrl_readRegA == ctrl_writeReg)) data_readRegA = data_writeReg;
    if (tap_wr_ok && (ctrl_readRegA == tap_addr))       data_readRegA = tap_data;
`else
`endif
    if (ctrl_readRegA == '0) data_readRegA = '0;
  end

  always_comb begin
    data_readRegB = regs_q[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    if (core_wr_ok && (ctrl_readRegB == ctrl_writeReg)) data_readRegB = data_writeReg;
    if (tap_wr_ok && (ctrl_readRegB == tap_addr))       data_readRegB = tap_data;
`else
`endif
    if (ctrl_readRegB == '0) data_readRegB = '0;
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
    assign taps_out[g*W +: W] = regs_q[g+1];
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign wr_err   = wr_err_q;

endmodule
